// File: rtl/snake_pkg.sv
// ============================================================================
// snake_pkg: shared types, grid constants and direction helper. Rev 1.0
// ============================================================================
`default_nettype none

package snake_pkg;

  localparam int GRID_W  = 16;
  localparam int GRID_H  = 12;
  localparam int X_W     = 4;
  localparam int Y_W     = 4;
  localparam int LEN_W   = 8;
  localparam int MAX_LEN = 140;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    SCAN   = 3'd2,
    WAIT   = 3'd3,
    REPORT = 3'd4
  } state_t;

  // The encoding places each direction two steps from its opposite.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/snake_next_pos.sv
// ============================================================================
// snake_next_pos: combinational next head cell and wall detection. Rev 1.0
// ============================================================================
`default_nettype none

module snake_next_pos #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int X_W    = 4,
  parameter int Y_W    = 4
) (
  input  logic [X_W-1:0]  i_head_x,
  input  logic [Y_W-1:0]  i_head_y,
  input  snake_pkg::dir_t i_dir,
  output logic [X_W-1:0]  o_next_x,
  output logic [Y_W-1:0]  o_next_y,
  output logic            o_wall
);

  import snake_pkg::*;

  always_comb begin
    o_next_x = i_head_x;
    o_next_y = i_head_y;
    o_wall   = 1'b0;
    case (i_dir)
      UP: begin
        o_wall   = (i_head_y == '0);
        o_next_y = i_head_y - Y_W'(1);
      end
      RIGHT: begin
        o_wall   = (i_head_x == X_W'(GRID_W - 1));
        o_next_x = i_head_x + X_W'(1);
      end
      DOWN: begin
        o_wall   = (i_head_y == Y_W'(GRID_H - 1));
        o_next_y = i_head_y + Y_W'(1);
      end
      LEFT: begin
        o_wall   = (i_head_x == '0);
        o_next_x = i_head_x - X_W'(1);
      end
      default: begin
        o_wall = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/snake_collision_detector.sv
// ============================================================================
// snake_collision_detector: per-tick wall/apple/body check with serial body
// scan; emits one goodColl/badColl outcome per accepted tick. Rev 1.0
// ============================================================================
`default_nettype none

module snake_collision_detector #(
  parameter int GRID_W  = snake_pkg::GRID_W,
  parameter int GRID_H  = snake_pkg::GRID_H,
  parameter int X_W     = snake_pkg::X_W,
  parameter int Y_W     = snake_pkg::Y_W,
  parameter int LEN_W   = snake_pkg::LEN_W,
  parameter int MAX_LEN = snake_pkg::MAX_LEN
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             tick,
  input  logic [1:0]       dir,
  input  logic [X_W-1:0]   head_x,
  input  logic [Y_W-1:0]   head_y,
  input  logic [X_W-1:0]   apple_x,
  input  logic [Y_W-1:0]   apple_y,
  input  logic [LEN_W-1:0] length,
  output logic [LEN_W-1:0] body_addr,
  input  logic [X_W-1:0]   body_x,
  input  logic [Y_W-1:0]   body_y,
  output logic [X_W-1:0]   next_x,
  output logic [Y_W-1:0]   next_y,
  output logic             busy,
  output logic             done,
  output logic             goodColl,
  output logic             badColl,
  output logic             overrun
);

  import snake_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  dir_t              r_last_dir;
  dir_t              w_dir_req;
  dir_t              w_dir_eff;
  logic [X_W-1:0]    r_next_x;
  logic [Y_W-1:0]    r_next_y;
  logic [X_W-1:0]    w_next_x;
  logic [Y_W-1:0]    w_next_y;
  logic              w_wall;
  logic              w_ate;
  logic              r_wall;
  logic              r_ate;
  logic              r_hit;
  logic              r_cmp_valid;
  logic              r_overrun;
  logic [LEN_W-1:0]  r_addr;
  logic [LEN_W-1:0]  r_scan_n;
  logic [LEN_W-1:0]  w_len_clamp;
  logic [LEN_W-1:0]  w_scan_n;
  logic              w_last_addr;
  logic              w_match;

  assign w_dir_req = dir_t'(dir);
  assign w_dir_eff = (w_dir_req == opposite(r_last_dir)) ? r_last_dir : w_dir_req;

  snake_next_pos #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_next_pos (
    .i_head_x (head_x),
    .i_head_y (head_y),
    .i_dir    (w_dir_eff),
    .o_next_x (w_next_x),
    .o_next_y (w_next_y),
    .o_wall   (w_wall)
  );

  // A wall hit masks the apple; the tail only vacates when nothing is eaten.
  assign w_ate       = ~w_wall & (w_next_x == apple_x) & (w_next_y == apple_y);
  assign w_len_clamp = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
  assign w_scan_n    = (w_len_clamp == '0) ? '0 :
                       (w_ate ? w_len_clamp : w_len_clamp - LEN_W'(1));

  assign w_last_addr = (r_addr == r_scan_n - LEN_W'(1));
  assign w_match     = (body_x == r_next_x) && (body_y == r_next_y);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    goodColl    = 1'b0;
    badColl     = 1'b0;
    case (r_state)
      IDLE: begin
        if (tick) w_state_nxt = CALC;
      end
      CALC: begin
        busy        = 1'b1;
        w_state_nxt = (w_wall || (w_scan_n == '0)) ? REPORT : SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (w_last_addr) w_state_nxt = WAIT;
      end
      WAIT: begin
        busy        = 1'b1;
        w_state_nxt = REPORT;
      end
      REPORT: begin
        busy        = 1'b1;
        done        = 1'b1;
        badColl     = r_wall | r_hit;
        goodColl    = r_ate & ~(r_wall | r_hit);
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Segment data lags its address by one cycle, so compares trail SCAN by one.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_last_dir  <= RIGHT;
      r_next_x    <= '0;
      r_next_y    <= '0;
      r_wall      <= 1'b0;
      r_ate       <= 1'b0;
      r_hit       <= 1'b0;
      r_cmp_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_addr      <= '0;
      r_scan_n    <= '0;
    end else begin
      r_cmp_valid <= (r_state == SCAN);
      if (tick && (r_state != IDLE)) r_overrun <= 1'b1;
      case (r_state)
        CALC: begin
          r_last_dir <= w_dir_eff;
          r_next_x   <= w_next_x;
          r_next_y   <= w_next_y;
          r_wall     <= w_wall;
          r_ate      <= w_ate;
          r_hit      <= 1'b0;
          r_scan_n   <= w_scan_n;
          if (!w_wall && (w_scan_n != '0)) r_addr <= '0;
        end
        SCAN: begin
          if (!w_last_addr) r_addr <= r_addr + LEN_W'(1);
        end
        default: begin
        end
      endcase
      if (r_cmp_valid && w_match) r_hit <= 1'b1;
    end
  end

  assign body_addr = r_addr;
  assign next_x    = r_next_x;
  assign next_y    = r_next_y;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_snake_collision_detector.sv
// ============================================================================
// tb_snake_collision_detector: directed scenarios with hand-computed outcomes
// against a behavioural body RAM. Rev 1.0
// ============================================================================
`default_nettype none

module tb_snake_collision_detector;

  logic       clk;
  logic       nRst;
  logic       tick;
  logic [1:0] dir;
  logic [3:0] head_x, head_y, apple_x, apple_y;
  logic [7:0] length;
  logic [7:0] body_addr;
  logic [3:0] body_x, body_y;
  logic [3:0] next_x, next_y;
  logic       busy, done, goodColl, badColl, overrun;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] mem_x [0:255];
  logic [3:0] mem_y [0:255];
  logic [7:0] addr_log [0:159];

  int   t_done_cyc, t_good_cyc, t_bad_cyc;
  int   t_done_n, t_good_n, t_bad_n, t_both_n;
  logic t_busy1, t_busy_end;

  snake_collision_detector dut (
    .clk       (clk),
    .nRst      (nRst),
    .tick      (tick),
    .dir       (dir),
    .head_x    (head_x),
    .head_y    (head_y),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .length    (length),
    .body_addr (body_addr),
    .body_x    (body_x),
    .body_y    (body_y),
    .next_x    (next_x),
    .next_y    (next_y),
    .busy      (busy),
    .done      (done),
    .goodColl  (goodColl),
    .badColl   (badColl),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    body_x <= mem_x[body_addr];
    body_y <= mem_y[body_addr];
  end

  task automatic clear_body();
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = 4'd15;
      mem_y[i] = 4'd11;
    end
  endtask

  task automatic set_seg(input int idx, input logic [3:0] x, input logic [3:0] y);
    mem_x[idx] = x;
    mem_y[idx] = y;
  endtask

  task automatic apply_reset();
    nRst = 1'b0;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
  endtask

  // Tick is raised in cycle 0; sampling at negedge c observes cycle c.
  task automatic run_tick(input logic [1:0] d, input logic [3:0] hx, input logic [3:0] hy,
                          input logic [3:0] ax, input logic [3:0] ay, input logic [7:0] len,
                          input int ncyc, input int extra_tick_cyc);
    @(negedge clk);
    dir = d; head_x = hx; head_y = hy; apple_x = ax; apple_y = ay; length = len;
    tick = 1'b1;
    t_done_cyc = -1; t_good_cyc = -1; t_bad_cyc = -1;
    t_done_n = 0; t_good_n = 0; t_bad_n = 0; t_both_n = 0;
    t_busy1 = 1'b0;
    addr_log[0] = body_addr;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      tick = (c == extra_tick_cyc);
      if (c == 2) begin
        head_x = 4'd0; head_y = 4'd0; apple_x = 4'd0; apple_y = 4'd0;
        length = 8'd0; dir = 2'd0;
      end
      if (c == 1) t_busy1 = busy;
      addr_log[c] = body_addr;
      if (done)     begin t_done_n++; t_done_cyc = c; end
      if (goodColl) begin t_good_n++; t_good_cyc = c; end
      if (badColl)  begin t_bad_n++;  t_bad_cyc  = c; end
      if (goodColl && badColl) t_both_n++;
    end
    tick = 1'b0;
    t_busy_end = busy;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    nRst = 1'b0; tick = 1'b0;
    #1;
    obs = {done, goodColl, badColl, busy, overrun, next_x, next_y, body_addr};
    n_vec++;
    if (obs !== 21'd0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {done, goodColl, badColl, busy, overrun, next_x, next_y, body_addr};
    n_vec++;
    if (obs !== 21'd0) begin n_err++; $display("FAIL reset_idle_outputs: got %h expected 0", obs); end
  endtask

  task automatic test_wall();
    apply_reset(); clear_body();
    run_tick(2'd1, 4'd15, 4'd5, 4'd0, 4'd0, 8'd3, 10, -1);
    n_vec++;
    if (t_bad_cyc !== 2) begin n_err++; $display("FAIL wall_bad_cycle: got %0d expected 2", t_bad_cyc); end
    n_vec++;
    if (t_good_n !== 0 || t_bad_n !== 1 || t_done_n !== 1) begin
      n_err++; $display("FAIL wall_pulse_counts: good %0d bad %0d done %0d expected 0 1 1", t_good_n, t_bad_n, t_done_n);
    end
    for (int c = 1; c <= 10; c++) begin
      n_vec++;
      if (addr_log[c] !== 8'd0) begin n_err++; $display("FAIL wall_addr_idle c%0d: got %0d expected 0", c, addr_log[c]); end
    end
  endtask

  task automatic test_apple();
    apply_reset(); clear_body();
    set_seg(0, 4'd4, 4'd4); set_seg(1, 4'd3, 4'd4); set_seg(2, 4'd2, 4'd4);
    run_tick(2'd1, 4'd4, 4'd4, 4'd5, 4'd4, 8'd3, 10, -1);
    n_vec++;
    if (t_good_cyc !== 6 || t_good_n !== 1 || t_bad_n !== 0) begin
      n_err++; $display("FAIL apple_good: cycle %0d count %0d bad %0d expected 6 1 0", t_good_cyc, t_good_n, t_bad_n);
    end
    n_vec++;
    if ({next_x, next_y} !== {4'd5, 4'd4}) begin n_err++; $display("FAIL apple_next: got (%0d,%0d) expected (5,4)", next_x, next_y); end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (addr_log[2+k] !== 8'(k)) begin n_err++; $display("FAIL apple_addr%0d: got %0d expected %0d", k, addr_log[2+k], k); end
    end
    n_vec++;
    if (t_busy1 !== 1'b1 || t_busy_end !== 1'b0) begin
      n_err++; $display("FAIL apple_busy: cycle1 %b end %b expected 1 0", t_busy1, t_busy_end);
    end
  endtask

  task automatic test_reversal();
    apply_reset(); clear_body();
    run_tick(2'd3, 4'd6, 4'd2, 4'd0, 4'd9, 8'd1, 8, -1);
    n_vec++;
    if ({next_x, next_y} !== {4'd7, 4'd2}) begin n_err++; $display("FAIL reversal_next: got (%0d,%0d) expected (7,2)", next_x, next_y); end
    n_vec++;
    if (t_done_cyc !== 2 || t_good_n !== 0 || t_bad_n !== 0) begin
      n_err++; $display("FAIL reversal_done: cycle %0d good %0d bad %0d expected 2 0 0", t_done_cyc, t_good_n, t_bad_n);
    end
  endtask

  task automatic test_body_hit();
    apply_reset(); clear_body();
    set_seg(0, 4'd4, 4'd4); set_seg(1, 4'd4, 4'd5); set_seg(2, 4'd3, 4'd5); set_seg(3, 4'd3, 4'd4);
    run_tick(2'd2, 4'd4, 4'd4, 4'd10, 4'd10, 8'd4, 10, -1);
    n_vec++;
    if (t_bad_cyc !== 6 || t_good_n !== 0 || t_both_n !== 0) begin
      n_err++; $display("FAIL body_hit_bad: cycle %0d good %0d both %0d expected 6 0 0", t_bad_cyc, t_good_n, t_both_n);
    end
    n_vec++;
    if ({next_x, next_y} !== {4'd4, 4'd5}) begin n_err++; $display("FAIL body_hit_next: got (%0d,%0d) expected (4,5)", next_x, next_y); end
  endtask

  task automatic test_tail_chase();
    apply_reset(); clear_body();
    set_seg(0, 4'd2, 4'd2); set_seg(1, 4'd2, 4'd3); set_seg(2, 4'd3, 4'd3); set_seg(3, 4'd2, 4'd1);
    run_tick(2'd0, 4'd2, 4'd2, 4'd9, 4'd9, 8'd4, 10, -1);
    n_vec++;
    if (t_done_cyc !== 6 || t_bad_n !== 0 || t_good_n !== 0) begin
      n_err++; $display("FAIL tail_vacates: done %0d bad %0d good %0d expected 6 0 0", t_done_cyc, t_bad_n, t_good_n);
    end
    run_tick(2'd0, 4'd2, 4'd2, 4'd2, 4'd1, 8'd4, 10, -1);
    n_vec++;
    if (t_bad_cyc !== 7 || t_good_n !== 0) begin
      n_err++; $display("FAIL tail_with_apple: bad cycle %0d good %0d expected 7 0", t_bad_cyc, t_good_n);
    end
  endtask

  task automatic test_len_bounds();
    apply_reset(); clear_body();
    run_tick(2'd1, 4'd4, 4'd4, 4'd5, 4'd4, 8'd0, 8, -1);
    n_vec++;
    if (t_good_cyc !== 2 || t_bad_n !== 0) begin
      n_err++; $display("FAIL len0_good: cycle %0d bad %0d expected 2 0", t_good_cyc, t_bad_n);
    end
    run_tick(2'd1, 4'd0, 4'd0, 4'd9, 4'd9, 8'd200, 150, -1);
    n_vec++;
    if (t_done_cyc !== 142 || t_done_n !== 1) begin
      n_err++; $display("FAIL len_clamp_done: cycle %0d count %0d expected 142 1", t_done_cyc, t_done_n);
    end
    n_vec++;
    if (addr_log[142] !== 8'd138) begin n_err++; $display("FAIL len_clamp_last_addr: got %0d expected 138", addr_log[142]); end
  endtask

  task automatic test_overrun_reset();
    logic [20:0] obs;
    int pulses;
    apply_reset(); clear_body();
    set_seg(0, 4'd4, 4'd4); set_seg(1, 4'd3, 4'd4); set_seg(2, 4'd2, 4'd4);
    run_tick(2'd1, 4'd4, 4'd4, 4'd9, 4'd9, 8'd3, 12, 3);
    n_vec++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    n_vec++;
    if (t_done_n !== 1 || t_done_cyc !== 5 || t_bad_n !== 0 || t_good_n !== 0) begin
      n_err++; $display("FAIL overrun_single_done: count %0d cycle %0d bad %0d good %0d expected 1 5 0 0",
                        t_done_n, t_done_cyc, t_bad_n, t_good_n);
    end
    set_seg(1, 4'd5, 4'd4);
    @(negedge clk);
    dir = 2'd1; head_x = 4'd4; head_y = 4'd4; apple_x = 4'd9; apple_y = 4'd9; length = 8'd3;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b0;
    #1;
    obs = {done, goodColl, badColl, busy, overrun, next_x, next_y, body_addr};
    n_vec++;
    if (obs !== 21'd0) begin n_err++; $display("FAIL midscan_reset_outputs: got %h expected 0", obs); end
    @(negedge clk);
    nRst = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || goodColl || badColl) pulses++;
    end
    n_vec++;
    if (pulses !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL midscan_no_pulse: pulses %0d busy %b expected 0 0", pulses, busy);
    end
  endtask

  initial begin
    nRst = 1'b0; tick = 1'b0; dir = 2'd1;
    head_x = '0; head_y = '0; apple_x = '0; apple_y = '0; length = '0;
    clear_body();
    test_reset();
    test_wall();
    test_apple();
    test_reversal();
    test_body_hit();
    test_tail_chase();
    test_len_bounds();
    test_overrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/snake_collision_detector.md
Name: snake_collision_detector

Overview:
- Producer of the `goodColl`/`badColl` single-cycle pulses consumed by the score tracker.
- On each game tick it computes the snake's next head cell from the direction input.
- It checks that cell against the walls, the apple and every stored body segment, and reports exactly one outcome per tick.
- Body segments are read serially through a synchronous read port into the body RAM, which lives in the snake movement block.

Parameters:
- GRID_W, 16, playfield width in cells; x range 0..GRID_W-1
- GRID_H, 12, playfield height in cells; y range 0..GRID_H-1
- X_W, 4, width of x coordinates
- Y_W, 4, width of y coordinates
- LEN_W, 8, width of length and body address
- MAX_LEN, 140, maximum body length (equals the tracker's max score)

Ports:
- clk  in  1  system clock (hz100 at top)
- nRst  in  1  asynchronous active-low reset
- tick  in  1  one-cycle step request
- dir  in  2  requested direction: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1)
- head_x  in  X_W  current head x
- head_y  in  Y_W  current head y
- apple_x  in  X_W  apple x
- apple_y  in  Y_W  apple y
- length  in  LEN_W  current body length, head included at index 0
- body_addr  out  LEN_W  body RAM read address
- body_x  in  X_W  segment x; valid the cycle after body_addr
- body_y  in  Y_W  segment y; valid the cycle after body_addr
- next_x  out  X_W  registered next head x
- next_y  out  Y_W  registered next head y
- busy  out  1  high from the cycle after tick acceptance until REPORT ends
- done  out  1  one-cycle pulse in REPORT
- goodColl  out  1  one-cycle pulse: apple eaten, no fatal hit
- badColl  out  1  one-cycle pulse: wall or body hit
- overrun  out  1  sticky: a tick arrived while busy

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - last_dir = 1 (right)
  - overrun cleared only by reset
- States and transitions:
  - IDLE: tick=1 accepts the step and moves to CALC; tick=0 stays.
  - CALC:
    - Effective direction = dir, except when dir is the exact opposite of last_dir; then use last_dir. last_dir updates to the effective direction.
    - next_x/next_y are registered.
    - wall = head_x==0 going left, head_x==GRID_W-1 going right, head_y==0 going up, or head_y==GRID_H-1 going down. A wall hit suppresses the apple check.
    - ate = next cell equals apple.
    - Scan count N: N = length if ate, otherwise N = length-1 (the tail vacates). Length above MAX_LEN is clamped to MAX_LEN; length 0 gives N=0.
    - wall or N==0 goes to REPORT; otherwise goes to SCAN.
  - SCAN:
    - Presents body_addr = 0..N-1 on consecutive cycles.
    - Each returned segment is compared the cycle after its address.
    - Any match sets hit.
    - After the last address, goes to WAIT.
  - WAIT: compares the final returned segment, then goes to REPORT.
  - REPORT (one cycle):
    - done=1
    - badColl = wall | hit
    - goodColl = ate & ~(wall | hit)
    - Returns to IDLE.
- Pulse rules: goodColl and badColl are never high together. At most one pulse pair per accepted tick.
- Latency from the tick sample edge:
  - wall hit or N==0: pulses in cycle +2
  - otherwise: pulses in cycle +N+3
- Scan runs to completion even after an early hit, so latency is fixed.
- Ticks while busy or in REPORT are dropped and set overrun.
- The head, apple and length inputs are sampled only in CALC; later changes are ignored.
- body_addr holds its last value outside SCAN.
- Async reset mid-scan: immediate return to IDLE; no pulse is emitted.

Decomposition:
- Package snake_pkg holds:
  - dir_t enum (UP, RIGHT, DOWN, LEFT)
  - state_t enum (IDLE, CALC, SCAN, WAIT, REPORT)
  - GRID_W, GRID_H, X_W, Y_W, LEN_W, MAX_LEN
  - function opposite(dir_t)
- Sub-module snake_next_pos: purely combinational; takes head, effective direction and grid bounds; produces next_x, next_y, wall.

Test Plan:
- Head (15,5), dir=1, length=3, body free → badColl in cycle +2; goodColl=0; no body_addr activity.
- Head (4,4), dir=1, apple (5,4), length=3, body {(4,4),(3,4),(2,4)} → N=3, addresses 0,1,2; goodColl at cycle +6; next=(5,4).
- Head (4,4), dir=2, body {(4,4),(4,5),(3,5),(3,4)}, no apple → N=3; the segment at index 1 matches (4,5); badColl at cycle +6.
- last_dir=1, dir=3, head (6,2), length=1 → reversal ignored; next=(7,2); N=0; done at +2; no pulses.
- Tail-chase: head (2,2), dir=0, length=4, tail at index 3 = (2,1), no apple → N=3 excludes the tail; no badColl. Repeat with the apple at (2,1) → N=4; badColl.
- Second tick during SCAN → overrun=1; exactly one done. Then assert nRst low mid-scan → all outputs 0; no pulse afterward.
